vec_operand_fetch: RTL and testbench
====================================

VEC_OPERAND_FETCH -- requirements
Module: vec_operand_fetch

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, element width; ADDR_WIDTH, 16, SRAM word address width; MAX_ELEMENTS, 4096, maximum vector length; FIFO_DEPTH, 4, output buffer entries (power of 2, >=2).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle command pulse; sampled only in IDLE.
REQ-005 busy  output  1  high whenever state != IDLE.
REQ-006 done  output  1  one-cycle pulse, high exactly while in DONE.
REQ-007 num_elements  input  $clog2(MAX_ELEMENTS)+1  vector length, 0..MAX_ELEMENTS; latched on start.
REQ-008 base_a, base_b  input  ADDR_WIDTH  operand start addresses; latched on start.
REQ-009 stride_a, stride_b  input  ADDR_WIDTH  signed two's-complement address increments; latched on start.
REQ-010 use_b  input  1  1 = binary op (fetch B), 0 = unary; latched on start.
REQ-011 mem_a_req, mem_b_req  output  1  read strobes for SRAM ports A/B.
REQ-012 mem_a_addr, mem_b_addr  output  ADDR_WIDTH  read addresses.
REQ-013 mem_a_rdata, mem_b_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after the matching req.
REQ-014 data_a_out, data_b_out  output  DATA_WIDTH  operand pair presented to the vector engine.
REQ-015 out_valid  output  1  pair valid; out_ready  input  1  consumer accepts; transfer when both high.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN, DONE; default/illegal state returns to IDLE.
REQ-017 IDLE: start with num_elements==0 -> DONE; start with num_elements>0 -> FETCH, latch config, clear issue/deliver counters.
REQ-018 FETCH: issue a read when issued < num_elements and (fifo_count + inflight) < FIFO_DEPTH; mem_a_req=1, mem_b_req=use_b, same cycle.
REQ-019 Element i address SHALL be base + i*stride, computed incrementally (addr += stride per issue), wrapping modulo 2^ADDR_WIDTH.
REQ-020 inflight is 1 for the cycle after an issue, else 0; returning rdata SHALL be written to the FIFO as {a, b}, with b=0 when use_b=0.
REQ-021 FETCH -> DRAIN on the cycle the last read issues (issued reaches num_elements).
REQ-022 DRAIN -> DONE when delivered == num_elements (FIFO empty, nothing inflight); DONE -> IDLE unconditionally next cycle.
REQ-023 out_valid SHALL equal FIFO not empty; data_*_out SHALL be the FIFO head, held stable while out_valid && !out_ready.
REQ-024 Simultaneous FIFO write and pop SHALL be allowed in one cycle with fifo_count unchanged; full-FIFO writes cannot occur by credit rule REQ-018.
REQ-025 Throughput with out_ready held high SHALL be one element per cycle; latency start -> first out_valid = 3 cycles (FETCH entry, issue, data return into FIFO).
REQ-026 mem_*_req SHALL be 0 outside FETCH; start while busy SHALL be ignored; no element may be duplicated or dropped.
REQ-027 Counters issued/delivered SHALL be $clog2(MAX_ELEMENTS)+1 bits so num_elements=MAX_ELEMENTS completes.

Reset
REQ-028 On rst_n low (any time, including mid-vector): state=IDLE, busy=0, done=0, out_valid=0, mem_a_req=0, mem_b_req=0, mem addresses=0, data outputs=0, FIFO emptied, counters=0; in-flight read data discarded.
REQ-029 After reset release, no output changes until a new start.

Verification
REQ-030 Unary: base_a=0x10, stride_a=1, num=4, use_b=0, out_ready=1, SRAM[0x10..0x13]={1,2,3,4} -> out_valid 4 consecutive cycles, A={1,2,3,4}, B=0, done 1 cycle after last, mem_b_req never high.
REQ-031 Binary strided: base_a=0, stride_a=2, base_b=0x100, stride_b=-1 (0xFFFF), num=3 -> A addrs 0,2,4; B addrs 0x100,0xFF,0xFE; pairs delivered in order.
REQ-032 Backpressure: num=8, out_ready=0 for 10 cycles then 1 -> exactly FIFO_DEPTH=4 reads issued before stall, out data held stable, all 8 delivered in order, none repeated.
REQ-033 Wrap: base_a=0xFFFE, stride_a=1, num=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-034 Zero length / max length: num=0 -> done 1 cycle after start, no mem_*_req; num=4096 -> 4096 transfers then done.
REQ-035 Reset mid-run: rst_n low after 2 of 6 elements -> all outputs zero immediately; subsequent start num=2 delivers only the new vector's 2 elements.

Source files
------------

// File: rtl/vec_operand_fetch.sv
// Vector operand fetch: streams element addresses to one or two SRAM read
// ports, collects the returning data into a small FIFO and presents
// {A, B} operand pairs to the vector engine.
`timescale 1ns/1ps

module vec_operand_fetch #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_ELEMENTS = 4096,
  parameter int FIFO_DEPTH   = 4,
  localparam int CNT_W       = $clog2(MAX_ELEMENTS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      num_elements_i,
  input  logic [ADDR_WIDTH-1:0] base_a_i,
  input  logic [ADDR_WIDTH-1:0] base_b_i,
  input  logic [ADDR_WIDTH-1:0] stride_a_i,
  input  logic [ADDR_WIDTH-1:0] stride_b_i,
  input  logic                  use_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_a_req_o,
  output logic                  mem_b_req_o,
  output logic [ADDR_WIDTH-1:0] mem_a_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_b_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_a_rdata_i,
  input  logic [DATA_WIDTH-1:0] mem_b_rdata_i,
  output logic [DATA_WIDTH-1:0] data_a_out_o,
  output logic [DATA_WIDTH-1:0] data_b_out_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            state_o
);

  // Output handshake: a pair transfers on every rising edge where
  // out_valid_o && out_ready_i. Once out_valid_o is raised it stays high and
  // the data stays unchanged until that transfer happens; out_valid_o never
  // depends combinationally on out_ready_i.

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        num_q;
  logic [CNT_W-1:0]        issued_q;
  logic [CNT_W-1:0]        delivered_q;
  logic [CNT_W-1:0]        delivered_d;
  logic                    use_b_q;
  logic [ADDR_WIDTH-1:0]   stride_a_q;
  logic [ADDR_WIDTH-1:0]   stride_b_q;
  logic [ADDR_WIDTH-1:0]   addr_a_q;
  logic [ADDR_WIDTH-1:0]   addr_b_q;
  logic                    inflight_q;

  logic [ENTRY_W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [PTR_W:0]          count_q;
  logic [PTR_W:0]          count_d;

  logic [PTR_W+1:0]        credit_used;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    out_valid;
  logic [ENTRY_W-1:0]      push_data;
  logic [ENTRY_W-1:0]      head;

  // A read may only issue when the FIFO is guaranteed room for its data,
  // counting the one read that may still be in flight.
  assign credit_used = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, inflight_q};
  assign issue       = (state_q == S_FETCH) && (issued_q < num_q) &&
                       (credit_used < (PTR_W+2)'(FIFO_DEPTH));

  assign push      = inflight_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready_i;
  assign push_data = {mem_a_rdata_i, (use_b_q ? mem_b_rdata_i : {DATA_WIDTH{1'b0}})};
  assign head      = fifo_mem_q[rd_ptr_q];

  // FIFO occupancy after this cycle's write and/or pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Delivered-element count after this cycle's pop.
  always_comb begin
    delivered_d = delivered_q;
    if (pop) begin
      delivered_d = delivered_q + CNT_W'(1);
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign state_o      = state_q;
  assign mem_a_req_o  = issue;
  assign mem_b_req_o  = issue && use_b_q;
  assign mem_a_addr_o = addr_a_q;
  assign mem_b_addr_o = addr_b_q;
  assign out_valid_o  = out_valid;
  // Stale FIFO entries are hidden so the data outputs read zero when empty.
  assign data_a_out_o = out_valid ? head[ENTRY_W-1 -: DATA_WIDTH] : '0;
  assign data_b_out_o = out_valid ? head[DATA_WIDTH-1:0] : '0;

  // Sequencer: command latch, address walk, issue/deliver bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      use_b_q     <= 1'b0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q  <= issue;
      delivered_q <= delivered_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (num_elements_i == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q     <= S_FETCH;
              num_q       <= num_elements_i;
              use_b_q     <= use_b_i;
              stride_a_q  <= stride_a_i;
              stride_b_q  <= stride_b_i;
              addr_a_q    <= base_a_i;
              addr_b_q    <= base_b_i;
              issued_q    <= '0;
              delivered_q <= '0;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            addr_a_q <= addr_a_q + stride_a_q;
            addr_b_q <= addr_b_q + stride_b_q;
            issued_q <= issued_q + CNT_W'(1);
            if ((issued_q + CNT_W'(1)) == num_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (delivered_d == num_q) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; returning read data lands here one cycle after issue.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_vec_operand_fetch.sv
// Bench for vec_operand_fetch: SRAM model, random/directed vectors, and a
// scoreboard built from base + i*stride arithmetic over the SRAM contents.
`timescale 1ns/1ps

module tb_vec_operand_fetch;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int MAXE  = 4096;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(MAXE) + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] num_elements = '0;
  logic [AW-1:0] base_a = '0, base_b = '0, stride_a = '0, stride_b = '0;
  logic          use_b = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] rdata_a = '0, rdata_b = '0;

  logic          busy, done, req_a, req_b, out_valid;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic [1:0]    state_dbg;

  vec_operand_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ELEMENTS(MAXE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_elements_i(num_elements),
    .base_a_i(base_a), .base_b_i(base_b), .stride_a_i(stride_a), .stride_b_i(stride_b),
    .use_b_i(use_b), .busy_o(busy), .done_o(done),
    .mem_a_req_o(req_a), .mem_b_req_o(req_b), .mem_a_addr_o(addr_a), .mem_b_addr_o(addr_b),
    .mem_a_rdata_i(rdata_a), .mem_b_rdata_i(rdata_b),
    .data_a_out_o(data_a), .data_b_out_o(data_b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .state_o(state_dbg)
  );

  // ---------------- SRAM model: data one cycle after req, junk otherwise ----------------
  logic [DW-1:0] sram_a [0:65535];
  logic [DW-1:0] sram_b [0:65535];

  always @(posedge clk) begin
    rdata_a <= req_a ? sram_a[addr_a] : DW'($urandom);
    rdata_b <= req_b ? sram_b[addr_b] : DW'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [2*DW-1:0] exp_q[$];
  logic [AW-1:0]   exp_addr_a_q[$];
  logic [AW-1:0]   exp_addr_b_q[$];
  bit              mon_en = 1'b0;
  bit              cur_use_b = 1'b0;
  int              vec_id = 0;
  int              ready_mode = 0;
  int              stall_until = 0;
  int              start_cyc = 0;

  // per-vector observations, cleared by the monitor when vec_id moves on
  int              vec_seen = 0;
  int              req_cnt = 0, pop_cnt = 0, stall_reqs = 0;
  int              first_valid_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1;
  bit              held = 1'b0;
  logic [2*DW-1:0] held_data = '0;

  // consumer ready pattern: 0 = always ready, 1 = random, 2 = stall window then ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = (cyc >= stall_until);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (!mon_en) begin
      held = 1'b0;
    end else begin
      if (vec_seen != vec_id) begin
        vec_seen = vec_id;
        req_cnt = 0; pop_cnt = 0; stall_reqs = 0;
        first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
      end
      check_eq("b_req_gate", 32'(req_b), 32'(req_a & cur_use_b));
      if (req_a) begin
        req_cnt++;
        if (!out_ready) stall_reqs++;
        if (exp_addr_a_q.size() == 0) begin
          check_eq("extra_req", 32'(exp_addr_a_q.size()), 1);
        end else begin
          check_eq("addr_a", 32'(addr_a), 32'(exp_addr_a_q.pop_front()));
          if (req_b) check_eq("addr_b", 32'(addr_b), 32'(exp_addr_b_q[0]));
          void'(exp_addr_b_q.pop_front());
        end
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (held) begin
        check_eq("hold_valid", 32'(out_valid), 1);
        check_eq("hold_data", 32'({data_a, data_b}), 32'(held_data));
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("extra_out", 32'(exp_q.size()), 1);
        end else begin
          check_eq("out_pair", 32'({data_a, data_b}), 32'(exp_q.pop_front()));
        end
      end
      held      = out_valid && !out_ready;
      held_data = {data_a, data_b};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_done"},  32'(done), 0);
    check_eq({tag, "_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_req_a"}, 32'(req_a), 0);
    check_eq({tag, "_req_b"}, 32'(req_b), 0);
    check_eq({tag, "_addr_a"}, 32'(addr_a), 0);
    check_eq({tag, "_addr_b"}, 32'(addr_b), 0);
    check_eq({tag, "_data_a"}, 32'(data_a), 0);
    check_eq({tag, "_data_b"}, 32'(data_b), 0);
    check_eq({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  task automatic launch_vec(input logic [AW-1:0] ba, input logic [AW-1:0] sa,
                            input logic [AW-1:0] bb, input logic [AW-1:0] sb,
                            input int num, input bit ub, input int mode);
    logic [AW-1:0] aa, ab;
    vec_id++;
    cur_use_b = ub;
    for (int i = 0; i < num; i++) begin
      aa = ba + AW'(i * sa);
      ab = bb + AW'(i * sb);
      exp_addr_a_q.push_back(aa);
      exp_addr_b_q.push_back(ab);
      exp_q.push_back({sram_a[aa], (ub ? sram_b[ab] : 8'h00)});
    end
    @(negedge clk);
    ready_mode   = mode;
    stall_until  = cyc + 10;
    start        = 1'b1;
    num_elements = CW'(num);
    base_a = ba; stride_a = sa; base_b = bb; stride_b = sb; use_b = ub;
    start_cyc = cyc;
    @(negedge clk);
    // scramble command inputs: the DUT must work from its latched copy
    start        = 1'b0;
    num_elements = CW'($urandom_range(0, 50));
    base_a = AW'($urandom); stride_a = AW'($urandom);
    base_b = AW'($urandom); stride_b = AW'($urandom);
    use_b  = 1'($urandom);
  endtask

  task automatic finish_vec(input int num, input int mode);
    bit seen;
    int done_cyc;
    int budget;
    seen = 1'b0;
    done_cyc = 0;
    budget = num * 8 + 100;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
      start = ($urandom_range(0, 7) == 0);  // must be ignored while busy
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_seen", 32'(seen), 1);
    if (seen) begin
      if (num == 0) check_eq("done_lat_zero", 32'(done_cyc - start_cyc), 1);
      else          check_eq("done_after_last", 32'(done_cyc - last_pop_cyc), 1);
      check_eq("req_count", 32'(req_cnt), 32'(num));
      check_eq("pop_count", 32'(pop_cnt), 32'(num));
      check_eq("exp_left", 32'(exp_q.size()), 0);
      if (num > 0) check_eq("first_valid_lat", 32'(first_valid_cyc - start_cyc), 3);
      if (mode == 0 && num > 0) check_eq("burst_len", 32'(last_pop_cyc - first_pop_cyc), 32'(num - 1));
      if (mode == 2 && num >= DEPTH) check_eq("stall_reqs", 32'(stall_reqs), DEPTH);
      @(negedge clk);
      check_eq("done_pulse", 32'(done), 0);
      check_eq("idle_busy", 32'(busy), 0);
    end
  endtask

  task automatic run_vec(input logic [AW-1:0] ba, input logic [AW-1:0] sa,
                         input logic [AW-1:0] bb, input logic [AW-1:0] sb,
                         input int num, input bit ub, input int mode);
    launch_vec(ba, sa, bb, sb, num, ub, mode);
    finish_vec(num, mode);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram_a[i] = DW'($urandom);
      sram_b[i] = DW'($urandom);
    end
    for (int i = 0; i < 4; i++) sram_a[16'h10 + i] = DW'(i + 1);

    repeat (3) @(negedge clk);
    check_reset_state("por");
    base_a = 16'h1234; stride_a = 16'h0005; num_elements = CW'(7); use_b = 1'b1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_state("post_rel");
    end
    mon_en = 1'b1;

    // unary, contiguous
    run_vec(16'h0010, 16'h0001, 16'h0000, 16'h0000, 4, 1'b0, 0);
    // binary, strided with negative B stride
    run_vec(16'h0000, 16'h0002, 16'h0100, 16'hFFFF, 3, 1'b1, 0);
    // backpressure window
    run_vec(AW'($urandom), 16'h0001, AW'($urandom), 16'h0001, 8, 1'b1, 2);
    // address wrap
    run_vec(16'hFFFE, 16'h0001, 16'h0001, 16'hFFFE, 4, 1'b1, 0);
    // zero length
    run_vec(16'h0040, 16'h0001, 16'h0080, 16'h0001, 0, 1'b1, 0);
    // maximum length
    run_vec(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), MAXE, 1'b1, 0);

    // reset in the middle of a vector
    launch_vec(AW'($urandom), 16'h0001, AW'($urandom), 16'h0003, 6, 1'b1, 0);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (pop_cnt >= 2) break;
    end
    check_eq("mid_pops", 32'(pop_cnt), 2);
    rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    check_reset_state("mid_rst");
    exp_q.delete();
    exp_addr_a_q.delete();
    exp_addr_b_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_state("mid_idle");
    end
    mon_en = 1'b1;
    run_vec(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 2, 1'b1, 0);

    // randomized vectors
    for (int v = 0; v < 10; v++) begin
      run_vec(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
              $urandom_range(1, 40), 1'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
